// File: rtl/clkgate_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : clkgate_ctrl_pkg
//  Description : Shared low_power definitions for the clock-gate enable
//                controller, the gated-RAM wrapper and their benches.
//                Holds the FSM state encoding and the default wake/idle
//                timing values.
//  Revision    : 1.0 - initial release
// ============================================================================
package clkgate_ctrl_pkg;

   // Encoding is visible on the 'state' port, so the values are fixed.
   typedef enum logic [1:0] {
      ST_OFF  = 2'd0,
      ST_WAKE = 2'd1,
      ST_ON   = 2'd2,
      ST_IDLE = 2'd3
   } cg_state_e;

   // Defaults shared with the gated-RAM wrapper so both agree on timing.
   localparam int DEF_IDLE_CYCLES = 8;
   localparam int DEF_WAKE_CYCLES = 2;

endpackage : clkgate_ctrl_pkg
`default_nettype wire

// File: rtl/clkgate_satcnt.sv
`default_nettype none
// ============================================================================
//  Module      : clkgate_satcnt
//  Description : Parameterised up-counter that sticks at its maximum value
//                instead of wrapping. Synchronous clear has priority over
//                increment.
//  Ports       : clk   - clock
//                rst   - synchronous active-high reset (count -> 0)
//                clr   - synchronous clear (count -> 0), beats inc
//                inc   - count one this cycle
//                count - current value
//  Revision    : 1.0 - initial release
// ============================================================================
module clkgate_satcnt
   import clkgate_ctrl_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             inc,
   output logic [WIDTH-1:0] count
);

   localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};
   localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

   logic [WIDTH-1:0] count_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
      end else if (clr) begin
         count_q <= '0;
      end else if (inc && (count_q != CNT_MAX)) begin
         count_q <= count_q + CNT_ONE;
      end
   end

   assign count = count_q;

endmodule : clkgate_satcnt
`default_nettype wire

// File: rtl/clkgate_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : clkgate_ctrl
//  Description : Activity-driven clock-gate enable controller. Produces the
//                clken signal for the latch-based clock-gating cell in front
//                of the RAM. Any activity (req, busy, force_on) wakes the
//                clock; access is granted only after a wake-up delay; the
//                clock is gated again after a programmable idle timeout.
//                Cycles spent gated are counted for power statistics.
//  Ports       : clk       - ungated system clock
//                rst       - synchronous active-high reset
//                req       - client access request (level, held until gnt)
//                busy      - downstream operation in progress
//                force_on  - debug override, keeps the clock enabled
//                stat_clr  - synchronous clear of gated_cnt
//                clken     - enable to clock-gate cell (direct flop output)
//                gnt       - client may access the gated block this cycle
//                state     - current FSM state (OFF/WAKE/ON/IDLE = 0..3)
//                gated_cnt - saturating count of cycles spent in OFF
//  Revision    : 1.0 - initial release
// ============================================================================
module clkgate_ctrl
   import clkgate_ctrl_pkg::*;
#(
   parameter int IDLE_CYCLES = DEF_IDLE_CYCLES,
   parameter int WAKE_CYCLES = DEF_WAKE_CYCLES,
   parameter int CNT_W       = 4,
   parameter int STAT_W      = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req,
   input  logic              busy,
   input  logic              force_on,
   input  logic              stat_clr,
   output logic              clken,
   output logic              gnt,
   output logic [1:0]        state,
   output logic [STAT_W-1:0] gated_cnt
);

   // With WAKE_CYCLES == 0 the WAKE state is skipped entirely, so its load
   // value is never used; clamp it to zero to keep the constant in range.
   localparam bit               WAKE_SKIP = (WAKE_CYCLES == 0);
   localparam logic [CNT_W-1:0] WAKE_LOAD = WAKE_SKIP ? '0 : CNT_W'(WAKE_CYCLES - 1);
   localparam logic [CNT_W-1:0] IDLE_LOAD = CNT_W'(IDLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   cg_state_e        state_q, state_d;
   logic [CNT_W-1:0] wake_cnt_q, wake_cnt_d;
   logic [CNT_W-1:0] idle_cnt_q, idle_cnt_d;
   logic             clken_q;
   logic             act;

   assign act = req | busy | force_on;

   // ------------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------------
   always_comb begin
      state_d    = state_q;
      wake_cnt_d = wake_cnt_q;
      idle_cnt_d = idle_cnt_q;

      case (state_q)
         ST_OFF: begin
            if (act) begin
               if (WAKE_SKIP) begin
                  state_d = ST_ON;
               end else begin
                  state_d    = ST_WAKE;
                  wake_cnt_d = WAKE_LOAD;
               end
            end
         end

         // Once started, the wake-up sequence always completes even if the
         // activity goes away; the normal ON/IDLE timeout then gates again.
         ST_WAKE: begin
            if (wake_cnt_q == '0) begin
               state_d = ST_ON;
            end else begin
               wake_cnt_d = wake_cnt_q - CNT_ONE;
            end
         end

         ST_ON: begin
            if (!act) begin
               state_d    = ST_IDLE;
               idle_cnt_d = IDLE_LOAD;
            end
         end

         // Activity in IDLE returns to ON; the timer is reloaded on the
         // next ON->IDLE entry, so nothing carries over between idle spells.
         ST_IDLE: begin
            if (act) begin
               state_d = ST_ON;
            end else if (idle_cnt_q == '0) begin
               state_d = ST_OFF;
            end else begin
               idle_cnt_d = idle_cnt_q - CNT_ONE;
            end
         end

         default: begin
            state_d = ST_OFF;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // State register. clken is a separate flop loaded from the next state so
   // the gating cell sees a clean register output with no decode glitches,
   // while still tracking (state != OFF) exactly.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_OFF;
         wake_cnt_q <= '0;
         idle_cnt_q <= '0;
         clken_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         wake_cnt_q <= wake_cnt_d;
         idle_cnt_q <= idle_cnt_d;
         clken_q    <= (state_d != ST_OFF);
      end
   end

   // ------------------------------------------------------------------------
   // Gated-cycle statistics
   // ------------------------------------------------------------------------
   clkgate_satcnt #(
      .WIDTH (STAT_W)
   ) u_gated_cnt (
      .clk   (clk),
      .rst   (rst),
      .clr   (stat_clr),
      .inc   (state_q == ST_OFF),
      .count (gated_cnt)
   );

   // ------------------------------------------------------------------------
   // Outputs. gnt is open in IDLE too, so a request arriving during the idle
   // countdown is served in the same cycle it appears.
   // ------------------------------------------------------------------------
   assign clken = clken_q;
   assign state = state_q;
   assign gnt   = req & ((state_q == ST_ON) | (state_q == ST_IDLE));

endmodule : clkgate_ctrl
`default_nettype wire

// File: tb/tb_clkgate_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_clkgate_ctrl
//  Description : Self-checking bench for clkgate_ctrl. A behavioural model
//                predicts state/clken/gnt/gated_cnt for each applied cycle;
//                predictions are queued at drive time and compared after
//                the clock edge. gnt is also checked combinationally in the
//                cycle the inputs are applied.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_clkgate_ctrl;

   localparam int IDLE_C = 8;
   localparam int WAKE_C = 2;
   localparam int STAT_W = 4;

   localparam logic [1:0] S_OFF  = 2'd0;
   localparam logic [1:0] S_WAKE = 2'd1;
   localparam logic [1:0] S_ON   = 2'd2;
   localparam logic [1:0] S_IDLE = 2'd3;
   localparam logic [STAT_W-1:0] CNT_SAT = {STAT_W{1'b1}};

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              req = 1'b0;
   logic              busy = 1'b0;
   logic              force_on = 1'b0;
   logic              stat_clr = 1'b0;
   logic              clken;
   logic              gnt;
   logic [1:0]        state;
   logic [STAT_W-1:0] gated_cnt;

   always #5 clk = ~clk;

   clkgate_ctrl #(
      .IDLE_CYCLES (IDLE_C),
      .WAKE_CYCLES (WAKE_C),
      .CNT_W       (4),
      .STAT_W      (STAT_W)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .busy      (busy),
      .force_on  (force_on),
      .stat_clr  (stat_clr),
      .clken     (clken),
      .gnt       (gnt),
      .state     (state),
      .gated_cnt (gated_cnt)
   );

   typedef struct packed {
      logic [1:0]        st;
      logic              ck;
      logic              g;
      logic [STAT_W-1:0] cnt;
   } exp_t;

   exp_t sbq[$];

   int n_vec = 0;
   int n_err = 0;
   int cyc   = 0;

   // Reference model state
   logic [1:0]        m_state = S_OFF;
   int                m_el    = 0;     // cycles already spent in WAKE/IDLE
   logic [STAT_W-1:0] m_cnt   = '0;
   bit                m_valid = 1'b0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
      end
   endtask

   // Apply one cycle of inputs, predict the post-edge outputs, then compare.
   task automatic step(input logic r, input logic b, input logic f,
                       input logic c, input logic rs);
      logic [1:0]        n_state;
      int                n_el;
      logic [STAT_W-1:0] n_cnt;
      logic              act;
      exp_t              e;
      exp_t              got;

      req = r; busy = b; force_on = f; stat_clr = c; rst = rs;
      #1;
      if (m_valid)
         check("gnt_now", 32'(gnt), 32'(r & ((m_state == S_ON) || (m_state == S_IDLE))));

      n_state = m_state;
      n_el    = m_el;
      n_cnt   = m_cnt;
      act     = r | b | f;
      if (rs) begin
         n_state = S_OFF;
         n_el    = 0;
         n_cnt   = '0;
         m_valid = 1'b1;
      end else begin
         if (c)
            n_cnt = '0;
         else if ((m_state == S_OFF) && (m_cnt != CNT_SAT))
            n_cnt = m_cnt + 1'b1;
         case (m_state)
            S_OFF:  if (act) begin
                       n_state = (WAKE_C == 0) ? S_ON : S_WAKE;
                       n_el    = 0;
                    end
            S_WAKE: begin
                       n_el = m_el + 1;
                       if (n_el >= WAKE_C) n_state = S_ON;
                    end
            S_ON:   if (!act) begin
                       n_state = S_IDLE;
                       n_el    = 0;
                    end
            default: begin
                       if (act) n_state = S_ON;
                       else begin
                          n_el = m_el + 1;
                          if (n_el >= IDLE_C) n_state = S_OFF;
                       end
                    end
         endcase
      end
      m_state = n_state;
      m_el    = n_el;
      m_cnt   = n_cnt;

      e.st  = n_state;
      e.ck  = (n_state != S_OFF);
      e.g   = r & ((n_state == S_ON) || (n_state == S_IDLE));
      e.cnt = n_cnt;
      if (m_valid) sbq.push_back(e);

      @(posedge clk);
      #1;
      cyc++;
      if (m_valid) begin
         if (sbq.size() == 0) begin
            check("sb_empty", 32'd1, 32'd0);
         end else begin
            e = sbq.pop_front();
            got.st = state; got.ck = clken; got.g = gnt; got.cnt = gated_cnt;
            check("state",     32'(got.st),  32'(e.st));
            check("clken",     32'(got.ck),  32'(e.ck));
            check("gnt",       32'(got.g),   32'(e.g));
            check("gated_cnt", 32'(got.cnt), 32'(e.cnt));
         end
      end
   endtask

   task automatic quiet(input int n);
      repeat (n) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      // Reset, then idle: gated_cnt counts 1,2,3...
      repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      quiet(6);

      // Wake-up with held request: WAKE for two cycles, then ON with gnt
      repeat (6) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

      // Idle timeout back to OFF, a few gated cycles after
      quiet(12);

      // Idle abort: request returns mid-IDLE, gnt the same cycle
      repeat (4) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      quiet(3);
      repeat (3) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      quiet(11);

      // busy alone keeps the clock on without granting
      repeat (25) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      quiet(11);

      // force_on alone, then force_on rising in IDLE with no request
      repeat (25) step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      quiet(3);
      step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      quiet(11);

      // busy drops while req stays high in ON
      repeat (5) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      repeat (3) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      quiet(11);

      // Saturation of the 4-bit statistic, then clear and resume
      quiet(20);
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      quiet(3);

      // Clear while an increment would also happen, during activity
      step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      quiet(2);

      // Reset during WAKE
      quiet(12);
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      quiet(3);

      // Reset during IDLE
      repeat (4) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      quiet(3);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      quiet(3);

      // Random activity
      for (int i = 0; i < 400; i++) begin
         step(($urandom_range(0, 3) == 0),
              ($urandom_range(0, 7) == 0),
              ($urandom_range(0, 11) == 0),
              ($urandom_range(0, 29) == 0),
              ($urandom_range(0, 79) == 0));
      end
      quiet(2);

      if (sbq.size() != 0)
         check("sb_leftover", 32'(sbq.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule : tb_clkgate_ctrl
`default_nettype wire
